ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 tb/tb_ram_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the core (c_) and PIM (p_) ports, with lock runs and read-return routing.
// Build macro RAM_ARB_FIXED_PRIO_EN: the core always wins ARB ties instead of round-robin.
module ram_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int RD_LAT   = 2,
  parameter int LOCK_MAX = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            c_req,
  input  logic            c_we,
  input  logic            c_lock,
  input  logic [AW-1:0]   c_addr,
  input  logic [DW-1:0]   c_wdata,
  input  logic [DW/8-1:0] c_be,
  output logic            c_gnt,
  output logic            c_rvalid,
  output logic [DW-1:0]   c_rdata,
  input  logic            p_req,
  input  logic            p_we,
  input  logic            p_lock,
  input  logic [AW-1:0]   p_addr,
  input  logic [DW-1:0]   p_wdata,
  input  logic [DW/8-1:0] p_be,
  output logic            p_gnt,
  output logic            p_rvalid,
  output logic [DW-1:0]   p_rdata,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic            ram_wen,
  output logic            ram_rden,
  output logic [DW/8-1:0] ram_byteena,
  input  logic [DW-1:0]   ram_rdata
);
  localparam int BW = DW / 8;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_MAX);

  // state     | meaning
  // ST_ARB    | free arbitration between both ports
  // ST_LOCK_C | core owns the RAM for a lock run
  // ST_LOCK_P | PIM owns the RAM for a lock run
  localparam logic [1:0] ST_ARB    = 2'd0;
  localparam logic [1:0] ST_LOCK_C = 2'd1;
  localparam logic [1:0] ST_LOCK_P = 2'd2;

  logic [1:0]        state;
  logic              last_gnt_p;
  logic [CW-1:0]     lock_cnt;
  logic [RD_LAT-1:0] pipe_vld;
  logic [RD_LAT-1:0] pipe_own;

  logic              gnt_c, gnt_p, any_gnt;
  logic              sel_we, sel_lock;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic [BW-1:0]     sel_be;
  logic              in_lock;
  logic [CW-1:0]     run_cnt;
  logic              run_done;
  logic              ret_vld;

  assign in_lock = (state == ST_LOCK_C) || (state == ST_LOCK_P);

  always_comb begin
    gnt_c = 1'b0;
    gnt_p = 1'b0;
    if (!reset) begin
      case (state)
        ST_LOCK_C: gnt_c = c_req;
        ST_LOCK_P: gnt_p = p_req;
        default: begin
          if (c_req && p_req) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            gnt_c = 1'b1;
`else
            gnt_c = last_gnt_p;
            gnt_p = ~last_gnt_p;
`endif
          end else begin
            gnt_c = c_req;
            gnt_p = p_req;
          end
        end
      endcase
    end
  end

  assign any_gnt   = gnt_c | gnt_p;
  assign sel_we    = gnt_p ? p_we    : c_we;
  assign sel_lock  = gnt_p ? p_lock  : c_lock;
  assign sel_addr  = gnt_p ? p_addr  : c_addr;
  assign sel_wdata = gnt_p ? p_wdata : c_wdata;
  assign sel_be    = gnt_p ? p_be    : c_be;

  assign c_gnt       = gnt_c;
  assign p_gnt       = gnt_p;
  assign ram_addr    = any_gnt ? sel_addr  : '0;
  assign ram_wdata   = any_gnt ? sel_wdata : '0;
  assign ram_byteena = any_gnt ? sel_be    : '0;
  assign ram_wen     = any_gnt & sel_we & (|sel_be);
  assign ram_rden    = any_gnt & ~sel_we;

  // Grant count this access would bring the run to; the first locked grant counts as one.
  assign run_cnt  = in_lock ? (lock_cnt + CW'(1)) : CW'(1);
  assign run_done = (run_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_ARB;
      last_gnt_p <= 1'b1;
      lock_cnt   <= '0;
    end else if (in_lock) begin
      if (!any_gnt || !sel_lock || run_done) begin
        state      <= ST_ARB;
        lock_cnt   <= '0;
        last_gnt_p <= (state == ST_LOCK_P);
      end else begin
        lock_cnt <= run_cnt;
      end
    end else begin
      state <= ST_ARB;
      if (any_gnt) begin
        last_gnt_p <= gnt_p;
        if (sel_lock && !run_done) begin
          state    <= gnt_p ? ST_LOCK_P : ST_LOCK_C;
          lock_cnt <= run_cnt;
        end
      end
    end
  end

  // Read-return pipe tracks which port owns the data emerging from the RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      pipe_own <= '0;
    end else begin
      pipe_vld[0] <= any_gnt & ~sel_we;
      pipe_own[0] <= gnt_p;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_own[i] <= pipe_own[i-1];
      end
    end
  end

  assign ret_vld  = pipe_vld[RD_LAT-1] & ~reset;
  assign c_rvalid = ret_vld & ~pipe_own[RD_LAT-1];
  assign p_rvalid = ret_vld &  pipe_own[RD_LAT-1];
  assign c_rdata  = c_rvalid ? ram_rdata : '0;
  assign p_rdata  = p_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic checked against a behavioural model.
// Honours RAM_ARB_FIXED_PRIO_EN when the bundle is built with it.
module tb_ram_arbiter;
  localparam int AW = 10, DW = 32, BW = 4, RD_LAT = 2, LOCK_MAX = 16;

  logic clk, reset;
  logic c_req, c_we, c_lock, c_gnt, c_rvalid;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic [BW-1:0] c_be;
  logic p_req, p_we, p_lock, p_gnt, p_rvalid;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata, p_rdata;
  logic [BW-1:0] p_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic ram_wen, ram_rden;
  logic [BW-1:0] ram_byteena;

  ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata), .c_be(c_be),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .p_req(p_req), .p_we(p_we), .p_lock(p_lock), .p_addr(p_addr), .p_wdata(p_wdata), .p_be(p_be),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen), .ram_rden(ram_rden),
    .ram_byteena(ram_byteena), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM IP stand-in: address register then output register.
  logic pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] mem [0:1023];
  logic [AW-1:0] a_q;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd, input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (ram_wen) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_byteena);
    if (ram_rden) a_q <= ram_addr;
    ram_rdata <= mem[a_q];
  end

  // Reference model state
  typedef struct packed { int due; logic port; logic [DW-1:0] data; } ret_t;
  ret_t rq[$];
  logic [DW-1:0] exp_mem [0:1023];
  int owner;   // 0 none, 1 core, 2 PIM
  int run;
  bit last_p;
  int cyc;
  int n_tests, n_fail;
  bit g_c, g_p;
  logic obs_cg, obs_pg, obs_crv, obs_prv;
  logic [DW-1:0] obs_crd, obs_prd;
  logic [47:0] obs_bus;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void decide(input logic cr, input logic pr, output bit gc, output bit gp);
    gc = 0;
    gp = 0;
    if (owner == 1) gc = cr;
    else if (owner == 2) gp = pr;
    else if (cr && pr) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      gc = 1;
`else
      if (last_p) gc = 1;
      else gp = 1;
`endif
    end else begin
      gc = cr;
      gp = pr;
    end
  endfunction

  task automatic run_cycle();
    bit gc, gp, we, lk;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, mask;
    logic [BW-1:0] be;
    logic [47:0] exp_bus;
    logic [65:0] exp_ret;
    @(negedge clk);
    obs_cg = c_gnt; obs_pg = p_gnt; obs_crv = c_rvalid; obs_prv = p_rvalid;
    obs_crd = c_rdata; obs_prd = p_rdata;
    obs_bus = {ram_wen, ram_rden, ram_addr, ram_wdata, ram_byteena};
    gc = 0;
    gp = 0;
    if (reset) begin
      chk("rst_outs", {obs_cg, obs_pg, obs_crv, obs_prv, obs_bus, obs_crd, obs_prd}, '0);
      owner = 0; run = 0; last_p = 1;
      rq.delete();
    end else begin
      decide(c_req, p_req, gc, gp);
      chk("gnt", {obs_cg, obs_pg}, {gc, gp});
      we = gp ? p_we : c_we;
      lk = gp ? p_lock : c_lock;
      a  = gp ? p_addr : c_addr;
      wd = gp ? p_wdata : c_wdata;
      be = gp ? p_be : c_be;
      exp_bus = '0;
      if (gc || gp) exp_bus = {we && (be != 0), !we, a, wd, be};
      chk("ram_bus", obs_bus, exp_bus);
      exp_ret = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        if (rq[0].port) exp_ret[32:0] = {1'b1, rq[0].data};
        else exp_ret[65:33] = {1'b1, rq[0].data};
        void'(rq.pop_front());
      end
      chk("rd_ret", {obs_crv, obs_crd, obs_prv, obs_prd}, exp_ret);
      if (gc || gp) begin
        if (we) begin
          for (int b = 0; b < BW; b++) mask[b*8 +: 8] = {8{be[b]}};
          exp_mem[a] = (exp_mem[a] & ~mask) | (wd & mask);
        end else begin
          rq.push_back('{cyc + RD_LAT, gp, exp_mem[a]});
        end
        if (owner == 0) begin
          last_p = gp;
          if (lk) begin owner = gp ? 2 : 1; run = 1; end
        end else begin
          run++;
        end
        if (owner != 0 && (!lk || run >= LOCK_MAX)) begin
          owner = 0; run = 0; last_p = gp;
        end
      end else if (owner != 0) begin
        last_p = (owner == 2); owner = 0; run = 0;
      end
    end
    g_c = gc;
    g_p = gp;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_c(input logic rq_, input logic we, input logic lk, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
    c_req = rq_; c_we = we; c_lock = lk; c_addr = a; c_wdata = d; c_be = b;
  endtask

  task automatic set_p(input logic rq_, input logic we, input logic lk, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] b);
    p_req = rq_; p_we = we; p_lock = lk; p_addr = a; p_wdata = d; p_be = b;
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    case (i)
      5:       return 32'h11223344;
      16:      return 32'hAAAA0010;
      32:      return 32'hBBBB0020;
      default: return {16'hC0DE, 16'(i)};
    endcase
  endfunction

  initial begin
    int pct;
    n_tests = 0; n_fail = 0; cyc = 0;
    owner = 0; run = 0; last_p = 1;
    pl_en = 0; pl_addr = '0; pl_data = '0;
    reset = 1;
    // Requests held during reset must not reach the RAM.
    set_c(1, 1, 0, 10'h3FF, 32'hFFFFFFFF, 4'hF);
    set_p(1, 0, 1, 10'h3FE, 32'h0, 4'hF);
    for (int i = 0; i < 64; i++) begin
      pl_en = 1; pl_addr = AW'(i); pl_data = init_val(i);
      exp_mem[i] = init_val(i);
      run_cycle();
    end
    pl_en = 0;
    reset = 0;
    set_c(0, 0, 0, 0, 0, 0);
    set_p(0, 0, 0, 0, 0, 0);
    run_cycle();

    // Simultaneous reads: core first, PIM next, data in grant order.
    set_c(1, 0, 0, 10'h010, 0, 4'hF);
    set_p(1, 0, 0, 10'h020, 0, 4'hF);
    run_cycle(); chk("t1_cyc0_gnt", {obs_cg, obs_pg}, 2'b10);
    set_c(0, 0, 0, 0, 0, 0);
    run_cycle(); chk("t1_cyc1_gnt", {obs_cg, obs_pg}, 2'b01);
    set_p(0, 0, 0, 0, 0, 0);
    run_cycle(); chk("t1_c_ret", {obs_crv, obs_crd, obs_prv}, {1'b1, 32'hAAAA0010, 1'b0});
    run_cycle(); chk("t1_p_ret", {obs_prv, obs_prd, obs_crv}, {1'b1, 32'hBBBB0020, 1'b0});

    // Partial-byte write then read-back, and a zero-enable write.
    set_c(1, 1, 0, 10'h005, 32'hDEADBEEF, 4'b0011);
    run_cycle(); chk("t2_wr", {obs_cg, obs_bus[47]}, 2'b11);
    set_c(1, 0, 0, 10'h005, 0, 4'hF);
    run_cycle(); chk("t2_rd", {obs_cg, obs_bus[46]}, 2'b11);
    set_c(0, 0, 0, 0, 0, 0);
    run_cycle(); run_cycle();
    chk("t2_rd_data", {obs_crv, obs_crd}, {1'b1, 32'h1122BEEF});
    set_c(1, 1, 0, 10'h005, 32'hFFFFFFFF, 4'b0000);
    run_cycle(); chk("t2_be0", {obs_cg, obs_bus[47]}, 2'b10);
    set_c(1, 0, 0, 10'h005, 0, 4'hF);
    run_cycle();
    set_c(0, 0, 0, 0, 0, 0);
    run_cycle(); run_cycle();
    chk("t2_be0_data", {obs_crv, obs_crd}, {1'b1, 32'h1122BEEF});

    // PIM locks continuously against a waiting core: forced release after LOCK_MAX grants.
    set_c(1, 0, 0, 10'h001, 0, 4'hF);
    set_p(1, 0, 1, 10'h002, 0, 4'hF);
    for (int i = 0; i <= LOCK_MAX; i++) begin
      run_cycle();
      if (i < LOCK_MAX) chk("t3_p_run", {obs_cg, obs_pg}, 2'b01);
      else chk("t3_c_after", {obs_cg, obs_pg}, 2'b10);
    end
    set_c(0, 0, 0, 0, 0, 0);
    set_p(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_cycle();

    // PIM lock released by lock=0 on its third access.
    set_c(1, 0, 0, 10'h003, 0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      set_p(p_req || i == 0, 1, (i < 2), 10'h030, 32'h1000 + i, 4'hF);
      if (i == 3) set_p(0, 0, 0, 0, 0, 0);
      run_cycle();
      chk("t4_gnt", {obs_cg, obs_pg}, (i < 3) ? 2'b01 : 2'b10);
    end
    set_c(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_cycle();

    // Reset while a core read is in flight.
    set_c(1, 0, 0, 10'h010, 0, 4'hF);
    run_cycle(); chk("t5_gnt", obs_cg, 1'b1);
    reset = 1;
    set_p(1, 0, 0, 10'h011, 0, 4'hF);
    run_cycle();
    reset = 0;
    set_c(0, 0, 0, 0, 0, 0);
    set_p(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      run_cycle(); chk("t5_no_rvalid", {obs_crv, obs_prv}, 2'b00);
    end

    // Continuous unlocked contention.
    set_c(1, 0, 0, 10'h004, 0, 4'hF);
    set_p(1, 0, 0, 10'h008, 0, 4'hF);
    for (int i = 0; i < 8; i++) begin
      run_cycle();
`ifdef RAM_ARB_FIXED_PRIO_EN
      chk("t6_prio", {obs_cg, obs_pg}, 2'b10);
`else
      chk("t6_rr", {obs_cg, obs_pg}, (i % 2 == 0) ? 2'b10 : 2'b01);
`endif
    end
    set_c(0, 0, 0, 0, 0, 0);
    set_p(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) run_cycle();

    // Random traffic; the first half is biased towards long PIM lock runs.
    for (int i = 0; i < 3000; i++) begin
      pct = (i < 1500) ? 90 : 40;
      if (!c_req || g_c) begin
        if ($urandom_range(0, 9) < 7)
          set_c(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 63)),
                $urandom, BW'($urandom_range(0, 15)));
        else set_c(0, 0, 0, 0, 0, 0);
      end
      if (!p_req || g_p) begin
        if ($urandom_range(0, 99) < pct)
          set_p(1, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < pct), AW'($urandom_range(0, 63)),
                $urandom, BW'($urandom_range(0, 15)));
        else set_p(0, 0, 0, 0, 0, 0);
      end
      run_cycle();
    end
    set_c(0, 0, 0, 0, 0, 0);
    set_p(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) run_cycle();
    chk("drain_queue", 128'(rq.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
